// File: rtl/usr_pkg.sv
// Shared encodings for the universal-shift-register sequencer.
// Optional feature macro used by this codebase slice: USR_SEQ_ROTATE_EN (rotate support).
package usr_pkg;

    // Register width the sequencer is built for unless overridden.
    localparam int unsigned DefaultWidth = 5;

    // Command operation encoding.
    typedef enum logic [1:0] {
        OpLoad = 2'd0,
        OpShr  = 2'd1,
        OpShl  = 2'd2,
        OpRot  = 2'd3
    } op_e;

    // Mode encoding understood by the downstream universal shift register.
    typedef enum logic [1:0] {
        ModeHold  = 2'b00,
        ModeRight = 2'b01,
        ModeLeft  = 2'b10,
        ModeLoad  = 2'b11
    } mode_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/usr_sequencer_if.sv
// Command and register-control bundle between a command source, the sequencer
// and the downstream universal shift register.
// master: command source / register side; slave: the sequencer.
interface usr_sequencer_if #(
    parameter int unsigned WIDTH = usr_pkg::DefaultWidth,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CW-1:0]    cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic [WIDTH-1:0] q;
    logic [1:0]       mode;
    logic [WIDTH-1:0] parallel_in;
    logic             right_in;
    logic             left_in;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, q,
        input  cmd_ready, mode, parallel_in, right_in, left_in, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, q,
        output cmd_ready, mode, parallel_in, right_in, left_in, busy, done, err
    );

endinterface

// File: rtl/usr_sequencer.sv
// Sequencer that turns LOAD/SHR/SHL/ROT commands into per-cycle mode and serial
// inputs for a downstream universal shift register.
// Macro USR_SEQ_ROTATE_EN enables ROT; without it ROT completes at once with err.
module usr_sequencer
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input logic           clk,
    input logic           rst,
    usr_sequencer_if.slave bus
);

    localparam logic [CW-1:0] WidthCw = CW'(WIDTH);

    state_e           r_state;
    mode_e            r_mode;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_parallel_in;
    logic             r_right_in;
    logic             r_left_in;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_cmd_ready;

    op_e              w_op;
    logic [CW-1:0]    w_count;
    logic             w_accept;
    logic             w_right_in;

    assign w_op     = op_e'(bus.cmd_op);
    // Shift counts beyond the register width are clamped to the width.
    assign w_count  = (bus.cmd_count > WidthCw) ? WidthCw : bus.cmd_count;
    assign w_accept = bus.cmd_valid && r_cmd_ready;

`ifdef USR_SEQ_ROTATE_EN
    logic r_rot;

    // Rotate feeds the register's LSB straight back into its serial-right input.
    always_comb begin
        w_right_in = r_right_in;
        if (r_rot) begin
            w_right_in = bus.q[0];
        end
    end
`else
    logic w_unused_q;

    assign w_unused_q = ^bus.q;

    // Without rotate support the serial-right input is purely the latched fill.
    always_comb begin
        w_right_in = r_right_in;
    end
`endif

    // Command FSM with registered control outputs; reset abandons any command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_mode        <= ModeHold;
            r_cnt         <= '0;
            r_parallel_in <= '0;
            r_right_in    <= 1'b0;
            r_left_in     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_cmd_ready   <= 1'b1;
`ifdef USR_SEQ_ROTATE_EN
            r_rot         <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= w_count;
                        unique case (w_op)
                            OpLoad: begin
                                r_state       <= StLoad;
                                r_mode        <= ModeLoad;
                                r_parallel_in <= bus.cmd_data;
                            end
                            OpShr: begin
                                if (w_count == '0) begin
                                    r_state <= StDone;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state    <= StShift;
                                    r_mode     <= ModeRight;
                                    r_right_in <= bus.cmd_fill;
                                end
                            end
                            OpShl: begin
                                if (w_count == '0) begin
                                    r_state <= StDone;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state   <= StShift;
                                    r_mode    <= ModeLeft;
                                    r_left_in <= bus.cmd_fill;
                                end
                            end
                            OpRot: begin
`ifdef USR_SEQ_ROTATE_EN
                                if (w_count == '0) begin
                                    r_state <= StDone;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= StShift;
                                    r_mode  <= ModeRight;
                                    r_rot   <= 1'b1;
                                end
`else
                                // Unsupported op: finish immediately and flag it.
                                r_state <= StDone;
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
`endif
                            end
                            default: r_state <= StIdle;
                        endcase
                    end
                end
                StLoad: begin
                    r_state       <= StDone;
                    r_mode        <= ModeHold;
                    r_parallel_in <= '0;
                    r_done        <= 1'b1;
                end
                StShift: begin
                    if (r_cnt == CW'(1)) begin
                        r_state    <= StDone;
                        r_mode     <= ModeHold;
                        r_cnt      <= '0;
                        r_right_in <= 1'b0;
                        r_left_in  <= 1'b0;
                        r_done     <= 1'b1;
`ifdef USR_SEQ_ROTATE_EN
                        r_rot      <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                StDone: begin
                    r_state     <= StIdle;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.mode        = r_mode;
    assign bus.parallel_in = r_parallel_in;
    assign bus.right_in    = w_right_in;
    assign bus.left_in     = r_left_in;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;

endmodule

// File: doc/usr_sequencer.md
USR_SEQUENCER -- requirements
Module: usr_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 5: width of the controlled universal shift register.
REQ-002 SHALL have parameter CW, default $clog2(WIDTH+1): width of the shift count.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when both cmd_valid and cmd_ready are high.
REQ-007 cmd_op  input  2  operation: 0 LOAD, 1 SHR (shift right), 2 SHL (shift left), 3 ROT (rotate right).
REQ-008 cmd_count  input  CW  number of shift cycles (ignored for LOAD).
REQ-009 cmd_data  input  WIDTH  parallel load word.
REQ-010 cmd_fill  input  1  serial fill bit for SHR and SHL.
REQ-011 q  input  WIDTH  current register contents, fed back from downstream.
REQ-012 mode  output  2  register mode: 00 hold, 01 right, 10 left, 11 load.
REQ-013 parallel_in  output  WIDTH  load data to the register.
REQ-014 right_in, left_in  output  1 each  serial inputs to the register.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  one-cycle pulse that marks an unsupported op.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE.
REQ-019 cmd_ready SHALL equal 1 only in IDLE; on acceptance, SHALL latch op, count (clamped to WIDTH), data and fill.
REQ-020 After acceptance, the FSM SHALL move IDLE->LOAD for LOAD, and IDLE->SHIFT for SHR/SHL/ROT with count>0.
REQ-021 For SHR/SHL/ROT with count=0, the FSM SHALL move IDLE->DONE.
REQ-022 LOAD SHALL drive mode=11 and parallel_in=latched data for exactly one cycle, then move to DONE.
REQ-023 SHIFT SHALL drive mode=01 (SHR, ROT) or 10 (SHL) for exactly the latched count consecutive cycles, using a down-counter.
REQ-024 After the last shift cycle, SHIFT SHALL move to DONE.
REQ-025 SHR SHALL drive right_in=latched fill; SHL SHALL drive left_in=latched fill.
REQ-026 ROT SHALL drive right_in=q[0] combinationally in each shift cycle.
REQ-027 When not actively used, right_in, left_in and parallel_in SHALL be 0.
REQ-028 mode SHALL be 00 in IDLE and DONE.
REQ-029 DONE SHALL last one cycle with done=1 and then return to IDLE, so back-to-back commands have at least one idle cycle between them.
REQ-030 Latency from acceptance to the done pulse SHALL be 2 cycles for LOAD, count+1 cycles for a shift, and 1 cycle for count=0.
REQ-031 cmd_* changes while busy SHALL have no effect.

Reset
REQ-032 rst SHALL force state IDLE, the counter and latches to 0, mode=00, done=0, err=0, busy=0 and cmd_ready=1.
REQ-033 These values SHALL take effect immediately, including during LOAD or SHIFT; a partially executed command SHALL be abandoned with no done pulse.

Configuration
REQ-034 The macro USR_SEQ_ROTATE_EN SHALL select rotate support.
REQ-035 With USR_SEQ_ROTATE_EN defined, ROT SHALL behave as in REQ-026.
REQ-036 Without USR_SEQ_ROTATE_EN, an accepted ROT SHALL move IDLE->DONE, pulse done and err in the same cycle, and keep mode=00 throughout.
REQ-037 Without USR_SEQ_ROTATE_EN, err SHALL be tied 0 except in the REQ-036 case.

Structure
REQ-038 A shared package usr_pkg SHALL hold the op encoding enum, the mode encoding enum (HOLD/RIGHT/LEFT/LOAD), the state enum and the WIDTH default constant.
REQ-039 SHALL contain no sub-module; the bench SHALL instantiate the 5-bit universal shift register downstream and connect its q back to this block.

Verification
REQ-040 Reset then LOAD data=5'b10110 -> mode=11 for 1 cycle, q=10110, done 2 cycles after acceptance.
REQ-041 After REQ-040, SHR count=2 fill=1 -> mode=01 for 2 cycles, q=11101, done at acceptance+3.
REQ-042 After REQ-040, ROT count=5 (macro on) -> q returns to 10110; with the macro off -> done and err pulse together, q unchanged.
REQ-043 SHL count=7 fill=0 from q=11111 -> clamped to 5 cycles, q=00000; SHR count=0 -> done at acceptance+1, q unchanged.
REQ-044 Assert rst during the third cycle of SHL count=5 -> mode=00 and busy=0 immediately, no done pulse, cmd_ready=1 after release.
REQ-045 Hold cmd_valid high with changing cmd_data while busy -> only the first command executes; the next command is accepted only after DONE.
